// File: rtl/trap_sequencer_pkg.sv
// Shared trap-sequencing definitions: FSM state encoding, default drain depth and
// the lowest legal return PC (the same guard value the CSR file applies to mepc).
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_JUMP    = 3'd3,
    ST_HANDLER = 3'd4,
    ST_RETURN  = 3'd5
  } trap_state_e;

  localparam int          DRAIN_CYCLES_DEF = 2;
  localparam logic [31:0] CODE_BASE_DEF    = 32'h0000_0000;

  // Unsigned a >= b via the borrow of a 33-bit subtraction, so the compare stays
  // well-formed even when the base is zero.
  function automatic logic addr_ge(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return ~diff[32];
  endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: drains the pipeline, captures the return PC into mepc,
// redirects fetch to the handler vector, and restores or tail-chains on MRET.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter logic [31:0] CODE_BASE    = CODE_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interF,
  input  logic [31:0] interAddr,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        mret,
  input  logic [31:0] mepc_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        mepc_we,
  output logic [31:0] mepc_wdata,
  output logic        int_ack,
  output logic        in_handler,
  output logic [2:0]  dbg_state
);

  // Handshake: interF is a level held by the source until int_ack pulses; interAddr
  // is only meaningful while interF=1. redirect and mepc_we are single-cycle strobes
  // and their data buses are guaranteed stable in the strobe cycle.

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  trap_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pend, pend_n;
  logic [31:0]      vec_q, vec_n;
  logic [31:0]      epc_q, epc_n;
  logic             mepc_we_n;
  logic             int_ack_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_n    = pend;
    vec_n     = vec_q;
    epc_n     = epc_q;
    mepc_we_n = 1'b0;
    int_ack_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (interF) begin
          vec_n     = interAddr;
          int_ack_n = 1'b1;
          cnt_n     = CNT_LOAD;
          state_n   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The return PC is captured on the edge into SAVE so mepc_we is a clean register.
        if (!stall) begin
          if (cnt == '0) begin
            state_n = ST_SAVE;
            if (addr_ge(pc, CODE_BASE)) begin
              epc_n     = pc;
              mepc_we_n = 1'b1;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      ST_SAVE: state_n = ST_JUMP;
      ST_JUMP: state_n = ST_HANDLER;
      ST_HANDLER: begin
        // A nested trap is only remembered (latest vector wins) and served after MRET.
        if (interF) begin
          vec_n     = interAddr;
          pend_n    = 1'b1;
          int_ack_n = ~int_ack;
        end
        if (mret) state_n = ST_RETURN;
      end
      ST_RETURN: begin
        pend_n  = 1'b0;
        state_n = pend ? ST_HANDLER : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      vec_q      <= '0;
      epc_q      <= '0;
      redirect   <= 1'b0;
      flush      <= 1'b0;
      mepc_we    <= 1'b0;
      int_ack    <= 1'b0;
      in_handler <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      vec_q      <= vec_n;
      epc_q      <= epc_n;
      redirect   <= (state_n == ST_JUMP) || (state_n == ST_RETURN);
      flush      <= (state_n == ST_DRAIN) || (state_n == ST_SAVE) ||
                    (state_n == ST_JUMP)  || (state_n == ST_RETURN);
      mepc_we    <= mepc_we_n;
      int_ack    <= int_ack_n;
      in_handler <= (state_n == ST_JUMP) || (state_n == ST_HANDLER) ||
                    (state_n == ST_RETURN);
    end
  end

  always_comb begin
    redirect_pc = '0;
    case (state)
      ST_JUMP:   redirect_pc = vec_q;
      ST_RETURN: redirect_pc = pend ? vec_q : mepc_rdata;
      default:   redirect_pc = '0;
    endcase
  end

  assign mepc_wdata = epc_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized scoreboard bench for trap_sequencer: drivers push expected strobes
// (value + cycle) into queues, a negedge monitor pops and compares them.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam int          DRAIN = 2;
  localparam logic [31:0] CBASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        interF = 1'b0;
  logic [31:0] interAddr = '0;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] mepc_rdata = '0;
  logic        redirect, flush, mepc_we, int_ack, in_handler;
  logic [31:0] redirect_pc, mepc_wdata;
  logic [2:0]  dbg_state;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mepc_model = '0;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t exp_redir_q[$];
  exp_t exp_mepc_q[$];
  int   exp_ack_q[$];

  trap_sequencer #(.DRAIN_CYCLES(DRAIN), .CODE_BASE(CBASE)) dut (
    .clk(clk), .rst(rst), .interF(interF), .interAddr(interAddr), .pc(pc),
    .stall(stall), .mret(mret), .mepc_rdata(mepc_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .mepc_we(mepc_we), .mepc_wdata(mepc_wdata), .int_ack(int_ack),
    .in_handler(in_handler), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(redirect == 1'b0,    {tag, "_redirect"},    32'(redirect),   32'd0);
    chk(flush == 1'b0,       {tag, "_flush"},       32'(flush),      32'd0);
    chk(mepc_we == 1'b0,     {tag, "_mepc_we"},     32'(mepc_we),    32'd0);
    chk(int_ack == 1'b0,     {tag, "_int_ack"},     32'(int_ack),    32'd0);
    chk(in_handler == 1'b0,  {tag, "_in_handler"},  32'(in_handler), 32'd0);
    chk(redirect_pc == '0,   {tag, "_redirect_pc"}, redirect_pc,     32'd0);
    chk(mepc_wdata == '0,    {tag, "_mepc_wdata"},  mepc_wdata,      32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (redirect) begin
        if (exp_redir_q.size() == 0) begin
          chk(1'b0, "redirect_unexpected", redirect_pc, 32'd0);
        end else begin
          e = exp_redir_q.pop_front();
          chk(redirect_pc == e.val, "redirect_pc", redirect_pc, e.val);
          chk(cyc == e.cyc, "redirect_cycle", 32'(cyc), 32'(e.cyc));
          chk(flush == 1'b1, "redirect_flush", 32'(flush), 32'd1);
          chk(in_handler == 1'b1, "redirect_in_handler", 32'(in_handler), 32'd1);
        end
      end else if (exp_redir_q.size() > 0 && exp_redir_q[0].cyc <= cyc) begin
        e = exp_redir_q.pop_front();
        chk(1'b0, "redirect_missing", 32'd0, e.val);
      end
      if (mepc_we) begin
        if (exp_mepc_q.size() == 0) begin
          chk(1'b0, "mepc_we_unexpected", mepc_wdata, 32'd0);
        end else begin
          e = exp_mepc_q.pop_front();
          chk(mepc_wdata == e.val, "mepc_wdata", mepc_wdata, e.val);
          chk(cyc == e.cyc, "mepc_we_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (exp_mepc_q.size() > 0 && exp_mepc_q[0].cyc <= cyc) begin
        e = exp_mepc_q.pop_front();
        chk(1'b0, "mepc_we_missing", 32'd0, e.val);
      end
      if (int_ack) begin
        if (exp_ack_q.size() == 0) begin
          chk(1'b0, "int_ack_unexpected", 32'd1, 32'd0);
        end else begin
          chk(cyc == exp_ack_q[0], "int_ack_cycle", 32'(cyc), 32'(exp_ack_q[0]));
          void'(exp_ack_q.pop_front());
        end
      end else if (exp_ack_q.size() > 0 && exp_ack_q[0] <= cyc) begin
        chk(1'b0, "int_ack_missing", 32'd0, 32'(exp_ack_q[0]));
        void'(exp_ack_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: no stall, 1: stall the first three drain cycles, 2: random stall.
  // Expected redirect lands two cycles after the DRAIN-th unstalled drain cycle.
  task automatic do_trap(input logic [31:0] v, input logic [31:0] p, input int mode);
    int n_ok = 0;
    int n_st = 0;
    int guard = 0;
    tick;
    interF = 1'b1; interAddr = v; pc = p;
    exp_ack_q.push_back(cyc + 1);
    tick;
    interF = 1'b0; interAddr = $urandom;
    while (n_ok < DRAIN && guard < 100) begin
      guard++;
      case (mode)
        1:       stall = (n_st < 3);
        2:       stall = ($urandom_range(0, 2) == 0);
        default: stall = 1'b0;
      endcase
      if (stall) n_st++;
      else       n_ok++;
      if (n_ok == DRAIN) begin
        exp_redir_q.push_back('{v, cyc + 2});
        if (p >= CBASE) begin
          exp_mepc_q.push_back('{p, cyc + 1});
          mepc_model = p;
        end
      end
      @(negedge clk);
      chk(flush == 1'b1, "drain_flush", 32'(flush), 32'd1);
      tick;
    end
    stall = 1'($urandom_range(0, 1));
    mepc_rdata = mepc_model;
    tick;
    stall = 1'($urandom_range(0, 1));
    tick;
    stall = 1'b0;
    pc = $urandom;
  endtask

  // Runs a handler with n nested traps; 'same' puts the last nested trap in the
  // same cycle as MRET. Ends with a final MRET back to the saved mepc.
  task automatic do_handler(input int n, input bit same, input logic [31:0] first_vec);
    logic [31:0] nv;
    bit chained = 1'b0;
    nv = first_vec;
    for (int i = 0; i < n; i++) begin
      repeat (i == 0 ? $urandom_range(0, 2) : $urandom_range(1, 3)) tick;
      nv = (i == 0) ? first_vec : $urandom;
      interF = 1'b1; interAddr = nv;
      exp_ack_q.push_back(cyc + 1);
      if (same && i == n - 1) begin
        mret = 1'b1;
        exp_redir_q.push_back('{nv, cyc + 1});
        chained = 1'b1;
      end
      tick;
      interF = 1'b0; mret = 1'b0;
    end
    if (n > 0 && !chained) begin
      repeat ($urandom_range(1, 3)) tick;
      mret = 1'b1;
      exp_redir_q.push_back('{nv, cyc + 1});
      tick;
      mret = 1'b0;
      chained = 1'b1;
    end
    if (chained) begin
      tick;
      @(negedge clk);
      chk(in_handler == 1'b1, "chain_in_handler", 32'(in_handler), 32'd1);
    end
    repeat ($urandom_range(1, 3)) tick;
    mret = 1'b1;
    exp_redir_q.push_back('{mepc_model, cyc + 1});
    tick;
    mret = 1'b0;
    tick;
    @(negedge clk);
    chk(in_handler == 1'b0, "exit_in_handler", 32'(in_handler), 32'd0);
    chk(flush == 1'b0, "exit_flush", 32'(flush), 32'd0);
  endtask

  task automatic mret_in_idle;
    tick;
    mret = 1'b1;
    tick;
    mret = 1'b0;
    @(negedge clk);
    chk(redirect == 1'b0, "idle_mret_no_redirect", 32'(redirect), 32'd0);
  endtask

  task automatic reset_mid_drain;
    tick;
    interF = 1'b1; interAddr = 32'h0000_0500; pc = 32'h0000_1200;
    exp_ack_q.push_back(cyc + 1);
    tick;
    interF = 1'b0; stall = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_drain_reset");
    tick;
    tick;
    rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v, p;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk(dbg_state == 3'd0, "reset_state", 32'(dbg_state), 32'd0);
    tick;
    rst = 1'b1;
    tick;

    do_trap(32'h0000_0100, 32'h0000_1040, 0);
    do_handler(0, 1'b0, 32'd0);
    do_trap(32'h0000_0180, 32'h0000_1080, 1);
    do_handler(0, 1'b0, 32'd0);
    do_trap(32'h0000_0300, 32'h0000_1100, 0);
    do_handler(1, 1'b0, 32'h0000_0200);
    do_trap(32'h0000_0340, 32'h0000_1180, 0);
    do_handler(1, 1'b1, 32'h0000_0240);
    do_trap(32'h0000_0400, 32'h0000_0000, 0);
    do_handler(0, 1'b0, 32'd0);
    mret_in_idle();
    reset_mid_drain();
    do_trap(32'h0000_0600, 32'h0000_2000, 0);
    do_handler(0, 1'b0, 32'd0);

    repeat (40) begin
      v = $urandom & 32'hFFFF_FFFC;
      p = $urandom_range(0, 32'h3000) & 32'hFFFF_FFFE;
      do_trap(v, p, 2);
      do_handler($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) mret_in_idle();
    end

    repeat (6) tick;
    @(negedge clk);
    chk(exp_redir_q.size() == 0, "redirect_queue_empty", 32'(exp_redir_q.size()), 32'd0);
    chk(exp_mepc_q.size() == 0, "mepc_queue_empty", 32'(exp_mepc_q.size()), 32'd0);
    chk(exp_ack_q.size() == 0, "ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
